boreal_qrs_detector: RTL

- Downstream consumer of the biquad band-pass output.
- Performs Pan-Tompkins-style QRS detection on the filtered 24-bit ECG stream: derivative, squaring, moving-window integration (MWI), then a threshold/refractory state machine.
- Emits one beat pulse per detected QRS complex, with the MWI peak value and the RR interval in samples.
- Threshold and refractory period are runtime-loadable through the same small register interface the filter chain uses.

---
 rtl/boreal_pkg.sv | 34 +++
 rtl/boreal_qrs_detector_if.sv | 26 ++
 rtl/boreal_mwi.sv | 37 +++
 rtl/boreal_qrs_detector.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/boreal_pkg.sv
// Shared types and constants for the QRS detector slice: sample/MWI widths,
// register map, detector state encoding and the saturating square helper.
package boreal_pkg;

  localparam int SAMPLE_W = 24;
  localparam int MWI_W    = 32;
  localparam int DIFF_W   = SAMPLE_W + 1;
  localparam int PROD_W   = 2 * DIFF_W;
  localparam int RR_W     = 16;

  localparam logic [1:0] ADDR_THRESH_LO = 2'd0;
  localparam logic [1:0] ADDR_THRESH_HI = 2'd1;
  localparam logic [1:0] ADDR_REFRACT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISING  = 2'd1,
    ST_REFRACT = 2'd2
  } det_state_e;

  // Square of the derivative, scaled down and clipped to the MWI width.
  function automatic logic [MWI_W-1:0] square_sat(input logic signed [DIFF_W-1:0] d,
                                                  input int shift);
    logic signed [PROD_W-1:0] de;
    logic [PROD_W-1:0]        prod;
    logic [PROD_W-1:0]        scaled;
    de     = d;
    prod   = de * de;
    scaled = prod >> shift;
    if (|scaled[PROD_W-1:MWI_W]) square_sat = '1;
    else                         square_sat = scaled[MWI_W-1:0];
  endfunction

endpackage

// File: rtl/boreal_qrs_detector_if.sv
// Sample stream, register port and beat report of the QRS detector.
// master = producer/host side, slave = detector side.
interface boreal_qrs_detector_if;
  import boreal_pkg::*;

  logic                       valid;
  logic signed [SAMPLE_W-1:0] x_in;
  logic [1:0]                 reg_addr;
  logic [15:0]                reg_din;
  logic                       reg_we;
  logic [MWI_W-1:0]           mwi_out;
  logic                       beat;
  logic [MWI_W-1:0]           peak_val;
  logic [RR_W-1:0]            rr_interval;

  modport master (
    output valid, x_in, reg_addr, reg_din, reg_we,
    input  mwi_out, beat, peak_val, rr_interval
  );

  modport slave (
    input  valid, x_in, reg_addr, reg_din, reg_we,
    output mwi_out, beat, peak_val, rr_interval
  );

endinterface

// File: rtl/boreal_mwi.sv
// Moving-window integrator: running sum over the last 2^WIN_LOG2 inputs,
// kept in a circular buffer. The sum is wide enough that it can never wrap.
module boreal_mwi
  import boreal_pkg::*;
#(
  parameter int WIN_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = MWI_W + WIN_LOG2;

  logic [MWI_W-1:0]    win_buf [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;

  // Replace the oldest window entry with the new sample and adjust the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_buf[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (valid) begin
      sum             <= sum + SUM_W'(din) - SUM_W'(win_buf[wr_ptr]);
      win_buf[wr_ptr] <= din;
      wr_ptr          <= wr_ptr + WIN_LOG2'(1);
    end
  end

  assign dout = sum[SUM_W-1:WIN_LOG2];

endmodule

// File: rtl/boreal_qrs_detector.sv
// Pan-Tompkins style QRS detector: derivative -> square -> moving window
// integration -> threshold/refractory state machine reporting one beat pulse
// per QRS complex with its MWI peak and the RR interval in samples.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting for the MWI to rise strictly above thresh
//   ST_RISING  | inside a complex, tracking the MWI maximum until it falls
//              | back to thresh or below, which emits the beat
//   ST_REFRACT | hold-off after a beat, counting down refr_cnt valids;
//              | the MWI is ignored
module boreal_qrs_detector
  import boreal_pkg::*;
#(
  parameter int          WIN_LOG2        = 5,
  parameter int          SQ_SHIFT        = 16,
  parameter logic [31:0] DEFAULT_THRESH  = 32'd1000,
  parameter logic [15:0] DEFAULT_REFRACT = 16'd50
) (
  input logic                  clk,
  input logic                  rst,
  boreal_qrs_detector_if.slave bus
);

  logic [MWI_W-1:0]           thresh;
  logic [15:0]                refract;

  logic signed [SAMPLE_W-1:0] x_d1;
  logic signed [SAMPLE_W-1:0] x_d2;
  logic signed [DIFF_W-1:0]   diff;
  logic [MWI_W-1:0]           sq;
  logic [MWI_W-1:0]           mwi;

  det_state_e                 state;
  det_state_e                 state_nxt;
  logic [MWI_W-1:0]           peak;
  logic [MWI_W-1:0]           peak_nxt;
  logic [15:0]                refr_cnt;
  logic [15:0]                refr_cnt_nxt;
  logic                       first_beat;
  logic [RR_W-1:0]            smp_cnt;
  logic [RR_W-1:0]            rr_calc;
  logic                       emit;

  logic                       beat_r;
  logic [MWI_W-1:0]           peak_val_r;
  logic [RR_W-1:0]            rr_r;

  // Register file: thresh is written as two halves; address 3 is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh  <= DEFAULT_THRESH;
      refract <= DEFAULT_REFRACT;
    end else if (bus.reg_we) begin
      case (bus.reg_addr)
        ADDR_THRESH_LO: thresh[15:0]  <= bus.reg_din;
        ADDR_THRESH_HI: thresh[31:16] <= bus.reg_din;
        ADDR_REFRACT:   refract       <= bus.reg_din;
        default:        ;
      endcase
    end
  end

  // Derivative over a two-sample delay line, then the scaled saturating square.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_d1 <= '0;
      x_d2 <= '0;
      diff <= '0;
      sq   <= '0;
    end else if (bus.valid) begin
      x_d1 <= bus.x_in;
      x_d2 <= x_d1;
      diff <= {bus.x_in[SAMPLE_W-1], bus.x_in} - {x_d2[SAMPLE_W-1], x_d2};
      sq   <= square_sat(diff, SQ_SHIFT);
    end
  end

  boreal_mwi #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_mwi (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.valid),
    .din   (sq),
    .dout  (mwi)
  );

  // RR reported to the host; the very first beat has no predecessor.
  assign rr_calc = first_beat          ? '0 :
                   (smp_cnt == '1)     ? '1 :
                                         smp_cnt + RR_W'(1);

  // Detector next-state logic, evaluated only on valid samples.
  always_comb begin
    state_nxt    = state;
    peak_nxt     = peak;
    refr_cnt_nxt = refr_cnt;
    emit         = 1'b0;
    if (bus.valid) begin
      case (state)
        ST_IDLE: begin
          if (mwi > thresh) begin
            state_nxt = ST_RISING;
            peak_nxt  = mwi;
          end
        end
        ST_RISING: begin
          if (mwi > peak) peak_nxt = mwi;
          if (mwi <= thresh) begin
            emit         = 1'b1;
            refr_cnt_nxt = refract;
            state_nxt    = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          // A loaded count of 0 or 1 both end the hold-off after this valid.
          if (refr_cnt <= 16'd1) state_nxt = ST_IDLE;
          else                   refr_cnt_nxt = refr_cnt - 16'd1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Detector state, sample counter and the registered beat report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      peak       <= '0;
      refr_cnt   <= '0;
      first_beat <= 1'b1;
      smp_cnt    <= '0;
      beat_r     <= 1'b0;
      peak_val_r <= '0;
      rr_r       <= '0;
    end else begin
      state    <= state_nxt;
      peak     <= peak_nxt;
      refr_cnt <= refr_cnt_nxt;
      beat_r   <= emit;
      if (emit) begin
        peak_val_r <= peak;
        rr_r       <= rr_calc;
        first_beat <= 1'b0;
      end
      if (bus.valid) begin
        if (emit)                smp_cnt <= '0;
        else if (smp_cnt != '1)  smp_cnt <= smp_cnt + RR_W'(1);
      end
    end
  end

  assign bus.mwi_out     = mwi;
  assign bus.beat        = beat_r;
  assign bus.peak_val    = peak_val_r;
  assign bus.rr_interval = rr_r;

endmodule
